ps2_host_tx: RTL

//  PS/2 host-to-device transmitter; the send direction of the mouse PS/2 link, alongside the mouse receive path.

---
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_host_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - PS/2 host transmitter command and line bundle
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_drv_low;
    logic       ps2d_drv_low;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_drv_low, ps2d_drv_low, tx_idle, tx_done_tick, tx_err
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_drv_low, ps2d_drv_low, tx_idle, tx_done_tick, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 15000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic          CLK_100MHZ,
    input  logic          reset,
    ps2_host_tx_if.slave  bus
);
    localparam int RTS_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_ACK, S_WAIT
    } state_t;

    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fval_q, fval_d;
    logic                  fall_q;

    state_t           state_q;
    logic [8:0]       sh_q;
    logic [3:0]       n_q;
    logic [RTS_W-1:0] rts_q;
    logic [TO_W-1:0]  to_q;
    logic             c_drv_q, d_drv_q, idle_q, done_q, err_q;

    // Next filter state: shift in ps2c, change level only when the window is unanimous
    always_comb begin
        filt_d = {bus.ps2c_in, filt_q[FILTER_LEN-1:1]};
        fval_d = fval_q;
        if (filt_d == '0)
            fval_d = 1'b0;
        else if (filt_d == '1)
            fval_d = 1'b1;
    end

    // Glitch filter and registered falling-edge pulse of the device clock
    always_ff @(posedge CLK_100MHZ) begin
        if (!reset) begin
            filt_q <= '1;
            fval_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fval_q <= fval_d;
            fall_q <= fval_q & ~fval_d;
        end
    end

    // Transfer FSM: request-to-send, device-clocked shifting, ack capture, bus-idle wait
    always_ff @(posedge CLK_100MHZ) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            n_q     <= '0;
            rts_q   <= '0;
            to_q    <= '0;
            c_drv_q <= 1'b0;
            d_drv_q <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.wr_ps2) begin
                        sh_q    <= {~^bus.din, bus.din};
                        idle_q  <= 1'b0;
                        c_drv_q <= 1'b1;
                        rts_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_RTS;
                    end
                end
                S_RTS: begin
                    if (rts_q == RTS_LAST) begin
                        c_drv_q <= 1'b0;
                        d_drv_q <= 1'b1;
                        to_q    <= '0;
                        state_q <= S_START;
                    end else begin
                        rts_q <= rts_q + RTS_W'(1);
                    end
                end
                default: begin
                    to_q <= fall_q ? '0 : to_q + TO_W'(1);
                    if (state_q == S_WAIT && bus.ps2c_in && bus.ps2d_in) begin
                        done_q  <= 1'b1;
                        idle_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (fall_q) begin
                        case (state_q)
                            S_START: begin
                                d_drv_q <= ~sh_q[0];
                                n_q     <= '0;
                                state_q <= S_DATA;
                            end
                            S_DATA: begin
                                sh_q <= {1'b0, sh_q[8:1]};
                                n_q  <= n_q + 4'd1;
                                if (n_q == 4'd8) begin
                                    d_drv_q <= 1'b0;
                                    state_q <= S_STOP;
                                end else begin
                                    d_drv_q <= ~sh_q[1];
                                end
                            end
                            S_STOP: state_q <= S_ACK;
                            S_ACK: begin
                                err_q   <= bus.ps2d_in;
                                state_q <= S_WAIT;
                            end
                            default: ;
                        endcase
                    end else if (to_q == TO_LAST) begin
                        c_drv_q <= 1'b0;
                        d_drv_q <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        idle_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ps2c_drv_low = c_drv_q;
    assign bus.ps2d_drv_low = d_drv_q;
    assign bus.tx_idle      = idle_q;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_err       = err_q;
endmodule
